// File: rtl/mure_pkg.sv
// Shared types for the mure trace path: uop entries, exception info and encoder blocks.
// The idle-flush timer in mure_block_builder is enabled by defining MURE_IDLE_FLUSH_EN.
package mure_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 14;
  localparam int ITYPE_LEN   = 3;
  localparam int PRIV_LEN    = 2;
  localparam int CAUSE_LEN   = 5;

  localparam logic [1:0] IRETIRE_INC_C  = 2'd1;
  localparam logic [1:0] IRETIRE_INC_32 = 2'd2;

  typedef enum logic [ITYPE_LEN-1:0] {
    ITYPE_STD  = 3'd0,
    ITYPE_EXC  = 3'd1,
    ITYPE_INT  = 3'd2,
    ITYPE_ERET = 3'd3,
    ITYPE_NTB  = 3'd4,
    ITYPE_TB   = 3'd5,
    ITYPE_UIJ  = 3'd6,
    ITYPE_IJ   = 3'd7
  } itype_e;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    itype_e              itype;
    logic                compressed;
    logic [PRIV_LEN-1:0] priv;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
  } exc_info_s;

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    itype_e                 itype;
    logic [PRIV_LEN-1:0]    priv;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
  } blk_entry_s;

  function automatic logic [1:0] iretire_incr(input logic compressed);
    return compressed ? IRETIRE_INC_C : IRETIRE_INC_32;
  endfunction

  // cause/tval only travel with trap blocks; everything else reports zero
  function automatic blk_entry_s make_blk(input logic [XLEN-1:0]        iaddr,
                                          input logic [IRETIRE_LEN-1:0] iretire,
                                          input logic                   last32,
                                          input itype_e                 itype,
                                          input logic [PRIV_LEN-1:0]    priv,
                                          input exc_info_s              exc);
    blk_entry_s b;
    b.iaddr     = iaddr;
    b.iretire   = iretire;
    b.ilastsize = last32;
    b.itype     = itype;
    b.priv      = priv;
    b.cause     = '0;
    b.tval      = '0;
    if (itype == ITYPE_EXC || itype == ITYPE_INT) begin
      b.cause = exc.cause;
      b.tval  = exc.tval;
    end
    return b;
  endfunction

endpackage

// File: rtl/mure_idle_timer.sv
// Down-counter that reaches zero after CYCLES-1 enabled cycles following a clear.
// Used by mure_block_builder only when MURE_IDLE_FLUSH_EN is defined.
module mure_idle_timer #(
  parameter int CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // zero means the current cycle is the CYCLES-th idle one
  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mure_block_builder.sv
// Packs retired uops into E-trace instruction blocks with a one-entry output slot.
// Optional idle flush of partial blocks is enabled by defining MURE_IDLE_FLUSH_EN.
//
//   state | meaning
//   IDLE  | no block open; STD opens one, non-STD emits a single-instruction block
//   COUNT | block open; accumulating iretire until closing uop, flush or stall
module mure_block_builder
  import mure_pkg::*;
#(
  parameter int CNT_W        = IRETIRE_LEN,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 uop_valid_i,
  input  uop_entry_s           uop_entry_i,
  output logic                 uop_ready_o,
  input  exc_info_s            exc_info_i,
  input  logic                 flush_i,
  output logic                 blk_valid_o,
  input  logic                 blk_ready_i,
  output logic [XLEN-1:0]      blk_iaddr_o,
  output logic [CNT_W-1:0]     blk_iretire_o,
  output logic                 blk_ilastsize_o,
  output logic [ITYPE_LEN-1:0] blk_itype_o,
  output logic [PRIV_LEN-1:0]  blk_priv_o,
  output logic [CAUSE_LEN-1:0] blk_cause_o,
  output logic [XLEN-1:0]      blk_tval_o
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     iaddr_q, iaddr_d;
  logic [PRIV_LEN-1:0] priv_q, priv_d;
  logic                last32_q, last32_d;
  logic                pend_q, pend_d;
  logic                slot_vld_q, slot_vld_d;
  blk_entry_s          slot_q, slot_d;
  blk_entry_s          emit_blk;

  logic [1:0]          incr;
  logic [CNT_W:0]      cnt_sum;
  logic                slot_free, in_count, priv_chg, ovf, stall;
  logic                flush_req, accept, is_std, emit, idle_tc;

  assign incr      = iretire_incr(uop_entry_i.compressed);
  assign cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(incr);
  assign ovf       = cnt_sum[CNT_W];
  assign priv_chg  = (uop_entry_i.priv != priv_q);
  assign is_std    = (uop_entry_i.itype == ITYPE_STD);
  assign in_count  = (state_q == COUNT);
  assign slot_free = ~slot_vld_q | blk_ready_i;
  assign stall     = in_count & uop_valid_i & (priv_chg | ovf);
  // a pending flush keeps asserting until the slot frees up
  assign flush_req = in_count & (flush_i | pend_q | idle_tc);

  assign uop_ready_o = slot_free & ~stall & ~flush_req;
  assign accept      = uop_valid_i & uop_ready_o;

`ifdef MURE_IDLE_FLUSH_EN
  logic tmr_zero;

  mure_idle_timer #(
    .CYCLES (FLUSH_CYCLES)
  ) u_idle_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept | emit),
    .en_i   (in_count & ~accept),
    .tc_o   (tmr_zero)
  );

  assign idle_tc = tmr_zero & in_count;
`else
  assign idle_tc = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_std) state_d = COUNT;
      end
      COUNT: begin
        if (slot_free && (flush_req || stall)) state_d = IDLE;
        else if (accept && !is_std)            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    emit     = 1'b0;
    emit_blk = '0;
    cnt_d    = cnt_q;
    iaddr_d  = iaddr_q;
    priv_d   = priv_q;
    last32_d = last32_q;
    pend_d   = pend_q;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (accept) begin
          if (is_std) begin
            iaddr_d  = uop_entry_i.pc;
            cnt_d    = CNT_W'(incr);
            priv_d   = uop_entry_i.priv;
            last32_d = ~uop_entry_i.compressed;
          end else begin
            emit     = 1'b1;
            emit_blk = make_blk(uop_entry_i.pc, IRETIRE_LEN'(incr), ~uop_entry_i.compressed,
                                uop_entry_i.itype, uop_entry_i.priv, exc_info_i);
          end
        end
      end
      COUNT: begin
        if (slot_free && (flush_req || stall)) begin
          // forced close reports the accumulated block as plain STD
          emit     = 1'b1;
          emit_blk = make_blk(iaddr_q, IRETIRE_LEN'(cnt_q), last32_q, ITYPE_STD, priv_q, exc_info_i);
          pend_d   = 1'b0;
        end else begin
          if (flush_req) pend_d = 1'b1;
          if (accept) begin
            if (is_std) begin
              cnt_d    = cnt_sum[CNT_W-1:0];
              last32_d = ~uop_entry_i.compressed;
            end else begin
              emit     = 1'b1;
              emit_blk = make_blk(iaddr_q, IRETIRE_LEN'(cnt_sum[CNT_W-1:0]),
                                  ~uop_entry_i.compressed, uop_entry_i.itype,
                                  uop_entry_i.priv, exc_info_i);
            end
          end
        end
      end
      default: ;
    endcase
    slot_vld_d = emit | (slot_vld_q & ~blk_ready_i);
    slot_d     = emit ? emit_blk : slot_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      iaddr_q    <= '0;
      priv_q     <= '0;
      last32_q   <= 1'b0;
      pend_q     <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      iaddr_q    <= iaddr_d;
      priv_q     <= priv_d;
      last32_q   <= last32_d;
      pend_q     <= pend_d;
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
    end
  end

  if (CNT_W < IRETIRE_LEN) begin : g_iretire_hi
    logic unused_iretire_hi;
    assign unused_iretire_hi = |slot_q.iretire[IRETIRE_LEN-1:CNT_W];
  end

  assign blk_valid_o     = slot_vld_q;
  assign blk_iaddr_o     = slot_q.iaddr;
  assign blk_iretire_o   = slot_q.iretire[CNT_W-1:0];
  assign blk_ilastsize_o = slot_q.ilastsize;
  assign blk_itype_o     = slot_q.itype;
  assign blk_priv_o      = slot_q.priv;
  assign blk_cause_o     = slot_q.cause;
  assign blk_tval_o      = slot_q.tval;

endmodule

// File: tb/tb_mure_block_builder.sv
// Scoreboard bench for mure_block_builder: a block-level model predicts every block and
// every uop_ready_o value; a negedge monitor compares whatever the DUT presents.
module tb_mure_block_builder;
  import mure_pkg::*;

  localparam int CNT_W        = 3;
  localparam int FLUSH_CYCLES = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef MURE_IDLE_FLUSH_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 uop_valid_i = 1'b0;
  uop_entry_s           uop_entry_i = '0;
  logic                 uop_ready_o;
  exc_info_s            exc_info_i = '0;
  logic                 flush_i = 1'b0;
  logic                 blk_valid_o;
  logic                 blk_ready_i = 1'b1;
  logic [XLEN-1:0]      blk_iaddr_o;
  logic [CNT_W-1:0]     blk_iretire_o;
  logic                 blk_ilastsize_o;
  logic [ITYPE_LEN-1:0] blk_itype_o;
  logic [PRIV_LEN-1:0]  blk_priv_o;
  logic [CAUSE_LEN-1:0] blk_cause_o;
  logic [XLEN-1:0]      blk_tval_o;

  always #5 clk_i = ~clk_i;

  mure_block_builder #(.CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .uop_valid_i(uop_valid_i), .uop_entry_i(uop_entry_i),
    .uop_ready_o(uop_ready_o), .exc_info_i(exc_info_i), .flush_i(flush_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_iaddr_o(blk_iaddr_o),
    .blk_iretire_o(blk_iretire_o), .blk_ilastsize_o(blk_ilastsize_o), .blk_itype_o(blk_itype_o),
    .blk_priv_o(blk_priv_o), .blk_cause_o(blk_cause_o), .blk_tval_o(blk_tval_o)
  );

  typedef struct {
    logic [31:0] iaddr;
    int          iretire;
    logic        last32;
    itype_e      itype;
    logic [1:0]  priv;
    logic [4:0]  cause;
    logic [31:0] tval;
  } blk_t;

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state: one open block, occupancy of the output slot, pending flush, idle run
  bit          m_open, m_pend;
  logic [31:0] m_iaddr;
  int          m_cnt, m_idle, m_occ;
  logic        m_last32;
  logic [1:0]  m_priv;

  // last block handed to the encoder
  int          hs_cnt = 0;
  logic [31:0] hs_iaddr, hs_tval;
  logic [CNT_W-1:0] hs_iretire;
  logic        hs_last;
  logic [2:0]  hs_itype;
  logic [1:0]  hs_priv;
  logic [4:0]  hs_cause;

  bit rand_on = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(input logic [31:0] ia, input int n, input logic l32, input itype_e t,
                               input logic [1:0] p, input exc_info_s x);
    blk_t b;
    b.iaddr = ia; b.iretire = n; b.last32 = l32; b.itype = t; b.priv = p;
    b.cause = (t == ITYPE_EXC || t == ITYPE_INT) ? x.cause : 5'd0;
    b.tval  = (t == ITYPE_EXC || t == ITYPE_INT) ? x.tval : 32'd0;
    exp_q.push_back(b);
    m_occ++;
  endfunction

  function automatic void model_step();
    bit slot_free, flush_req, stall, exp_ready, accept, closed;
    int inc;
    uop_entry_s u;
    u = uop_entry_i;
    inc = u.compressed ? 1 : 2;
    slot_free = (m_occ == 0) || blk_ready_i;
    if (m_occ > 0 && blk_ready_i) m_occ--;
    closed    = 1'b0;
    flush_req = m_open && (flush_i || m_pend || (IDLE_EN && m_idle >= FLUSH_CYCLES - 1));
    stall     = m_open && uop_valid_i && (u.priv != m_priv || m_cnt + inc > CNT_MAX);
    exp_ready = slot_free && !flush_req && !stall;
    chk("uop_ready", uop_ready_o, exp_ready);
    accept = uop_valid_i && exp_ready;
    if (m_open && slot_free && (flush_req || stall)) begin
      push(m_iaddr, m_cnt, m_last32, ITYPE_STD, m_priv, exc_info_i);
      m_open = 1'b0; m_pend = 1'b0; closed = 1'b1;
    end else if (flush_req) begin
      m_pend = 1'b1;
    end
    if (accept) begin
      if (!m_open) begin
        if (u.itype == ITYPE_STD) begin
          m_open = 1'b1; m_iaddr = u.pc; m_cnt = inc; m_priv = u.priv; m_last32 = !u.compressed;
        end else begin
          push(u.pc, inc, !u.compressed, u.itype, u.priv, exc_info_i);
        end
      end else if (u.itype == ITYPE_STD) begin
        m_cnt += inc; m_last32 = !u.compressed;
      end else begin
        push(m_iaddr, m_cnt + inc, !u.compressed, u.itype, u.priv, exc_info_i);
        m_open = 1'b0;
      end
    end
    if (accept || closed || !m_open) m_idle = 0;
    else m_idle++;
  endfunction

  initial forever begin
    @(posedge clk_i);
    if (!rst_ni) begin
      m_open = 1'b0; m_pend = 1'b0; m_cnt = 0; m_idle = 0; m_occ = 0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // monitor: compare the presented block each cycle it is valid, pop on handshake
  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      chk("blk_valid", blk_valid_o, m_occ != 0);
      if (blk_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("blk_unexpected", 1'b1, 1'b0);
        end else begin
          chk("blk_iaddr", blk_iaddr_o, exp_q[0].iaddr);
          chk("blk_iretire", blk_iretire_o, exp_q[0].iretire);
          chk("blk_ilastsize", blk_ilastsize_o, exp_q[0].last32);
          chk("blk_itype", blk_itype_o, exp_q[0].itype);
          chk("blk_priv", blk_priv_o, exp_q[0].priv);
          chk("blk_cause", blk_cause_o, exp_q[0].cause);
          chk("blk_tval", blk_tval_o, exp_q[0].tval);
          if (blk_ready_i) void'(exp_q.pop_front());
        end
        if (blk_ready_i) begin
          hs_cnt++; hs_iaddr = blk_iaddr_o; hs_iretire = blk_iretire_o; hs_last = blk_ilastsize_o;
          hs_itype = blk_itype_o; hs_priv = blk_priv_o; hs_cause = blk_cause_o; hs_tval = blk_tval_o;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk_i); #1;
    if (rand_on) begin
      blk_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 99) < 3);
    end
  end

  task automatic send(input logic [31:0] pc, input itype_e t, input logic c, input logic [1:0] p,
                      input logic [4:0] cause, input logic [31:0] tval);
    int n;
    n = 0;
    uop_valid_i = 1'b1;
    uop_entry_i = '{pc: pc, itype: t, compressed: c, priv: p};
    exc_info_i  = '{cause: cause, tval: tval};
    forever begin
      @(negedge clk_i);
      if (uop_ready_o) break;
      n++;
      if (n > 200) begin
        chk("uop_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk_i); #1;
    uop_valid_i = 1'b0;
  endtask

  task automatic flush_pulse();
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic [1:0]  cur_priv;
    int          n;
    itype_e      t;
    logic        c;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_blk_valid", blk_valid_o, 1'b0);
    chk("rst_blk_iaddr", blk_iaddr_o, 32'd0);
    chk("rst_blk_iretire", blk_iretire_o, 0);
    chk("rst_blk_itype", blk_itype_o, 0);
    chk("rst_blk_cause", {blk_cause_o, blk_tval_o, blk_priv_o, blk_ilastsize_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    settle();

    // 1: three STD then a taken branch closes one block
    send(32'h100, ITYPE_STD, 1'b0, 2'd3, 5'd0, 32'd0);
    send(32'h104, ITYPE_STD, 1'b1, 2'd3, 5'd0, 32'd0);
    send(32'h106, ITYPE_STD, 1'b0, 2'd3, 5'd0, 32'd0);
    send(32'h10A, ITYPE_TB,  1'b1, 2'd3, 5'd0, 32'd0);
    settle();
    chk("t1_iaddr", hs_iaddr, 32'h100);
    chk("t1_iretire", hs_iretire, 6);
    chk("t1_ilastsize", hs_last, 1'b0);
    chk("t1_itype", hs_itype, ITYPE_TB);

    // 2: exception from IDLE
    send(32'h200, ITYPE_EXC, 1'b0, 2'd3, 5'd2, 32'hDEAD);
    settle();
    chk("t2_iaddr", hs_iaddr, 32'h200);
    chk("t2_iretire", hs_iretire, 2);
    chk("t2_ilastsize", hs_last, 1'b1);
    chk("t2_itype", hs_itype, ITYPE_EXC);
    chk("t2_cause_tval", {hs_cause, hs_tval}, {5'd2, 32'hDEAD});

    // 3: privilege change splits the block
    send(32'h300, ITYPE_STD, 1'b0, 2'd3, 5'd0, 32'd0);
    send(32'h304, ITYPE_STD, 1'b0, 2'd3, 5'd0, 32'd0);
    send(32'h308, ITYPE_STD, 1'b0, 2'd1, 5'd0, 32'd0);
    settle();
    chk("t3_iretire", hs_iretire, 4);
    chk("t3_priv_itype", {hs_priv, hs_itype}, {2'd3, ITYPE_STD});
    flush_pulse();
    settle();
    chk("t3_new_blk", {hs_iaddr, hs_priv}, {32'h308, 2'd1});

    // 4: saturation of the 3-bit accumulator
    for (int i = 0; i < 4; i++) send(32'h400 + 4 * i, ITYPE_STD, 1'b0, 2'd0, 5'd0, 32'd0);
    settle();
    chk("t4_iretire", hs_iretire, 6);
    chk("t4_itype", hs_itype, ITYPE_STD);
    flush_pulse();
    settle();
    chk("t4_next_blk", {hs_iaddr, 29'd0, hs_iretire}, {32'h40C, 29'd0, 3'd2});

    // 5: encoder backpressure
    blk_ready_i = 1'b0;
    send(32'h500, ITYPE_INT, 1'b1, 2'd0, 5'd7, 32'h1234);
    fork
      send(32'h502, ITYPE_TB, 1'b1, 2'd0, 5'd0, 32'd0);
      begin
        repeat (5) @(posedge clk_i);
        #1 blk_ready_i = 1'b1;
      end
    join
    settle();
    chk("t5_next_blk", {hs_iaddr, hs_itype}, {32'h502, ITYPE_TB});

`ifdef MURE_IDLE_FLUSH_EN
    // 6: idle flush fires FLUSH_CYCLES after the accept
    send(32'h600, ITYPE_STD, 1'b0, 2'd0, 5'd0, 32'd0);
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (!blk_valid_o && n < 50);
    chk("t6_flush_delay", n, FLUSH_CYCLES);
    settle();
    flush_pulse();
    repeat (4) @(posedge clk_i);
    #1;
    chk("t6_idle_flush_quiet", blk_valid_o, 1'b0);
`endif

    // randomized traffic
    rand_on  = 1'b1;
    pc       = 32'h8000_0000;
    cur_priv = 2'd3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 8) cur_priv = 2'($urandom_range(0, 3));
      t = ($urandom_range(0, 99) < 65) ? ITYPE_STD : itype_e'(3'($urandom_range(1, 7)));
      c = 1'($urandom_range(0, 1));
      send(pc, t, c, cur_priv, 5'($urandom_range(0, 31)), $urandom);
      pc = pc + (c ? 32'd2 : 32'd4);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(6, 14)) @(posedge clk_i);
      else repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    rand_on = 1'b0;
    @(posedge clk_i); #1;
    blk_ready_i = 1'b1;
    flush_i     = 1'b0;
    settle();
    flush_pulse();
    repeat (6) @(posedge clk_i);
    #1;
    chk("drain_empty", exp_q.size(), 0);

    // reset with an open block discards it
    send(32'h900, ITYPE_STD, 1'b0, 2'd0, 5'd0, 32'd0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mid_valid", blk_valid_o, 1'b0);
    rst_ni = 1'b1;
    n = hs_cnt;
    repeat (12) @(posedge clk_i);
    #1;
    chk("rst_mid_no_emit", hs_cnt, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
